// File: rtl/mem_seq_ctrl.sv
// Multi-cycle instruction sequencer for the PC/memory-address datapath.
// Walks FETCH/DECODE/EXEC/MEM/WB with req/ack memory handshakes and a sticky trap.
module mem_seq_ctrl #(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        mem_ack,
    input  logic        stall,
    output logic [1:0]  pc_sel,
    output logic        mem_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        rf_we,
    output logic        trap,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    state_e           state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0]      instret_q, instret_d;
    logic             legal, timeout_hit;
    logic             is_jump, is_branch, is_store, is_mem;

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_REG: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    assign is_jump   = (op_q == OP_JAL) || (op_q == OP_JALR);
    assign is_branch = (op_q == OP_BRANCH);
    assign is_store  = (op_q == OP_STORE);
    assign is_mem    = (op_q == OP_LOAD) || is_store;

    // Trap fires on the cycle whose missed ack would bring the count to TIMEOUT.
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        instret_d = instret_q;
        pc_sel    = 2'b11;
        mem_sel   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        rf_we     = 1'b0;
        trap      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!stall) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DECODE: begin
                op_d    = opcode;
                state_d = legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (is_mem) begin
                    state_d = S_MEM;
                    cnt_d   = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_sel = 1'b1;
                mem_req = 1'b1;
                mem_we  = is_store;
                if (mem_ack) begin
                    state_d = S_WB;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WB: begin
                pc_sel    = (is_jump || (is_branch && branch_taken)) ? 2'b00 : 2'b01;
                rf_we     = !(is_branch || is_store);
                instret_d = instret_q + 32'd1;
                if (stall) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            instret_q <= instret_d;
        end
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Directed bench for mem_seq_ctrl: per-cycle expected outputs go through a
// scoreboard queue and are checked with immediate assertions.
module tb_mem_seq_ctrl;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        mem_ack;
    logic        stall;
    logic [1:0]  pc_sel;
    logic        mem_sel;
    logic        mem_req;
    logic        mem_we;
    logic        ir_we;
    logic        rf_we;
    logic        trap;
    logic [2:0]  state;
    logic [31:0] instret;

    int checks   = 0;
    int failures = 0;

    mem_seq_ctrl #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ack      (mem_ack),
        .stall        (stall),
        .pc_sel       (pc_sel),
        .mem_sel      (mem_sel),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .ir_we        (ir_we),
        .rf_we        (rf_we),
        .trap         (trap),
        .state        (state),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, pc_sel, mem_sel, mem_req, mem_we, ir_we, rf_we, trap}
    logic [10:0] obs_v;
    assign obs_v = {state, pc_sel, mem_sel, mem_req, mem_we, ir_we, rf_we, trap};

    localparam logic [10:0] E_IDLE = {3'd0, 2'b11, 6'b000000};
    localparam logic [10:0] E_FW   = {3'd1, 2'b11, 6'b010000};
    localparam logic [10:0] E_FA   = {3'd1, 2'b11, 6'b010100};
    localparam logic [10:0] E_DEC  = {3'd2, 2'b11, 6'b000000};
    localparam logic [10:0] E_EXE  = {3'd3, 2'b11, 6'b000000};
    localparam logic [10:0] E_MLD  = {3'd4, 2'b11, 6'b110000};
    localparam logic [10:0] E_MST  = {3'd4, 2'b11, 6'b111000};
    localparam logic [10:0] E_WB1  = {3'd5, 2'b01, 6'b000010};
    localparam logic [10:0] E_WB1N = {3'd5, 2'b01, 6'b000000};
    localparam logic [10:0] E_WB0  = {3'd5, 2'b00, 6'b000000};
    localparam logic [10:0] E_WB0R = {3'd5, 2'b00, 6'b000010};
    localparam logic [10:0] E_TRAP = {3'd6, 2'b11, 6'b000001};

    typedef struct {
        string       tag;
        logic [10:0] v;
        logic [31:0] ir;
    } exp_t;

    exp_t sb_q[$];

    task automatic cyc(input string tag, input logic ack, input logic stl,
                       input logic bt, input logic rs,
                       input logic [10:0] ev, input logic [31:0] ei);
        exp_t e;
        mem_ack      = ack;
        stall        = stl;
        branch_taken = bt;
        rst          = rs;
        sb_q.push_back('{tag, ev, ei});
        #1;
        e = sb_q.pop_front();
        checks++;
        assert (obs_v === e.v) else begin
            failures++;
            $error("FAIL %s outputs obs=%b exp=%b", e.tag, obs_v, e.v);
        end
        checks++;
        assert (instret === e.ir) else begin
            failures++;
            $error("FAIL %s instret obs=%h exp=%h", e.tag, instret, e.ir);
        end
        @(negedge clk);
    endtask

    task automatic run_simple(input string tag, input logic [6:0] opc,
                              input logic bt, input logic stl,
                              input logic [10:0] wb, input logic [31:0] ir);
        opcode = opc;
        cyc({tag, "_f"}, 1'b1, 1'b0, 1'b0, 1'b0, E_FA, ir);
        cyc({tag, "_d"}, 1'b0, 1'b0, 1'b0, 1'b0, E_DEC, ir);
        cyc({tag, "_e"}, 1'b0, 1'b0, 1'b0, 1'b0, E_EXE, ir);
        cyc({tag, "_wb"}, 1'b0, stl, bt, 1'b0, wb, ir);
    endtask

    task automatic run_mem(input string tag, input logic [6:0] opc,
                           input int waits, input logic [10:0] me,
                           input logic [10:0] wb, input logic [31:0] ir);
        opcode = opc;
        cyc({tag, "_f"}, 1'b1, 1'b0, 1'b0, 1'b0, E_FA, ir);
        cyc({tag, "_d"}, 1'b1, 1'b0, 1'b0, 1'b0, E_DEC, ir);
        cyc({tag, "_e"}, 1'b1, 1'b0, 1'b0, 1'b0, E_EXE, ir);
        for (int i = 0; i < waits; i++)
            cyc({tag, "_mw"}, 1'b0, 1'b0, 1'b0, 1'b0, me, ir);
        cyc({tag, "_ma"}, 1'b1, 1'b0, 1'b0, 1'b0, me, ir);
        cyc({tag, "_wb"}, 1'b0, 1'b0, 1'b0, 1'b0, wb, ir);
    endtask

    initial begin
        rst          = 1'b1;
        opcode       = 7'b0010011;
        branch_taken = 1'b0;
        mem_ack      = 1'b0;
        stall        = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        cyc("reset", 1'b0, 1'b0, 1'b0, 1'b1, E_IDLE, 32'd0);
        cyc("idle", 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, 32'd0);
        for (int i = 0; i < 3; i++)
            run_simple("alu", 7'b0010011, 1'b0, 1'b0, E_WB1, 32'(i));

        run_mem("load", 7'b0000011, 2, E_MLD, E_WB1, 32'd3);
        run_simple("br_t", 7'b1100011, 1'b1, 1'b0, E_WB0, 32'd4);
        run_simple("br_nt", 7'b1100011, 1'b0, 1'b0, E_WB1N, 32'd5);
        run_mem("store", 7'b0100011, 0, E_MST, E_WB1N, 32'd6);
        run_simple("jal", 7'b1101111, 1'b0, 1'b0, E_WB0R, 32'd7);
        run_simple("jalr", 7'b1100111, 1'b0, 1'b0, E_WB0R, 32'd8);

        run_simple("wb_stall", 7'b0110011, 1'b0, 1'b1, E_WB1, 32'd9);
        cyc("idle_stall1", 1'b1, 1'b1, 1'b0, 1'b0, E_IDLE, 32'd10);
        cyc("idle_stall2", 1'b1, 1'b1, 1'b0, 1'b0, E_IDLE, 32'd10);
        cyc("idle_go", 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, 32'd10);

        opcode = 7'b0000011;
        cyc("fetch_stall", 1'b0, 1'b1, 1'b0, 1'b0, E_FW, 32'd10);
        cyc("fetch_stall_ack", 1'b1, 1'b1, 1'b0, 1'b0, E_FA, 32'd10);
        cyc("ld_d", 1'b0, 1'b0, 1'b0, 1'b0, E_DEC, 32'd10);
        cyc("ld_e", 1'b0, 1'b0, 1'b0, 1'b0, E_EXE, 32'd10);
        cyc("ld_mw", 1'b0, 1'b0, 1'b0, 1'b0, E_MLD, 32'd10);
        cyc("mem_rst", 1'b0, 1'b0, 1'b0, 1'b1, E_MLD, 32'd10);
        cyc("after_rst", 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, 32'd0);

        opcode = 7'b1111111;
        cyc("ill_f", 1'b1, 1'b0, 1'b0, 1'b0, E_FA, 32'd0);
        cyc("ill_d", 1'b0, 1'b0, 1'b0, 1'b0, E_DEC, 32'd0);
        cyc("ill_trap1", 1'b1, 1'b0, 1'b0, 1'b0, E_TRAP, 32'd0);
        cyc("ill_trap2", 1'b1, 1'b0, 1'b0, 1'b0, E_TRAP, 32'd0);
        cyc("ill_rst", 1'b0, 1'b0, 1'b0, 1'b1, E_TRAP, 32'd0);
        cyc("ill_idle", 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, 32'd0);

        opcode = 7'b0000011;
        for (int i = 0; i < 7; i++)
            cyc("late_fw", 1'b0, 1'b0, 1'b0, 1'b0, E_FW, 32'd0);
        cyc("late_fa", 1'b1, 1'b0, 1'b0, 1'b0, E_FA, 32'd0);
        cyc("late_d", 1'b0, 1'b0, 1'b0, 1'b0, E_DEC, 32'd0);
        cyc("late_e", 1'b0, 1'b0, 1'b0, 1'b0, E_EXE, 32'd0);
        for (int i = 0; i < 8; i++)
            cyc("mto_mw", 1'b0, 1'b0, 1'b0, 1'b0, E_MLD, 32'd0);
        cyc("mto_trap", 1'b0, 1'b0, 1'b0, 1'b0, E_TRAP, 32'd0);
        cyc("mto_rst", 1'b0, 1'b0, 1'b0, 1'b1, E_TRAP, 32'd0);
        cyc("mto_idle", 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, 32'd0);

        for (int i = 0; i < 8; i++)
            cyc("fto_fw", 1'b0, 1'b0, 1'b0, 1'b0, E_FW, 32'd0);
        cyc("fto_trap", 1'b0, 1'b0, 1'b0, 1'b0, E_TRAP, 32'd0);
        cyc("fto_rst", 1'b0, 1'b0, 1'b0, 1'b1, E_TRAP, 32'd0);

        force dut.instret_q = 32'hffff_ffff;
        cyc("pre_idle", 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, 32'hffff_ffff);
        release dut.instret_q;
        run_simple("wrap", 7'b0010011, 1'b0, 1'b0, E_WB1, 32'hffff_ffff);
        cyc("wrapped", 1'b0, 1'b0, 1'b0, 1'b0, E_FW, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
